// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed hex seven-segment scan driver
// Frame-synchronous shadow/display registers, leading-zero blanking and blink.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);
    localparam int SW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_POL    = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] SEL_POL = {NUM_DIGITS{ACTIVE_LOW}};

    logic [SW-1:0]           slot_q, slot_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
    logic                    sh_blz_q, sh_blz_d, disp_blz_q, disp_blz_d;
    logic                    sh_blk_q, sh_blk_d, disp_blk_q, disp_blk_d;
    logic                    fd_q, fd_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic                    slot_tick, boundary, blank, off;
    logic                    cur_dp, cur_lz;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   sel_raw;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        slot_tick   = (slot_q == SLOT_LAST);
        boundary    = slot_tick && (idx_q == IDX_LAST);
        slot_d      = slot_tick ? '0 : slot_q + 1'b1;
        idx_d       = idx_q;
        if (slot_tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (boundary) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // The boundary always sees the shadow as it was before a coincident load.
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_blz_d = disp_blz_q;
        disp_blk_d = disp_blk_q;
        if (boundary && pend_q) begin
            disp_val_d = sh_val_q;
            disp_dp_d  = sh_dp_q;
            disp_blz_d = sh_blz_q;
            disp_blk_d = sh_blk_q;
        end
        pend_d   = load ? 1'b1 : (boundary ? 1'b0 : pend_q);
        sh_val_d = load ? value    : sh_val_q;
        sh_dp_d  = load ? dp_in    : sh_dp_q;
        sh_blz_d = load ? blank_lz : sh_blz_q;
        sh_blk_d = load ? blink_en : sh_blk_q;
        fd_d     = boundary;

        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        sel_raw = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_raw[i] = (idx_q == IW'(i));
            if (idx_q == IW'(i)) begin
                cur_nib = disp_val_q[4*i +: 4];
                cur_dp  = disp_dp_q[i];
                cur_lz  = ((disp_val_q >> (4*i)) == '0);
            end
        end
        blank = disp_blz_q && cur_lz && (idx_q != '0);
        off   = blank || (disp_blk_q && phase_q);
        seg_d = (off ? 7'h00 : glyph(cur_nib)) ^ SEG_POL;
        dp_d  = (cur_dp && !off) ^ ACTIVE_LOW;
        sel_d = sel_raw ^ SEL_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pend_q      <= 1'b0;
            sh_val_q    <= '0;
            sh_dp_q     <= '0;
            sh_blz_q    <= 1'b0;
            sh_blk_q    <= 1'b0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            disp_blz_q  <= 1'b0;
            disp_blk_q  <= 1'b0;
            fd_q        <= 1'b0;
            seg_q       <= SEG_POL;
            dp_q        <= ACTIVE_LOW;
            sel_q       <= SEL_POL;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            sh_val_q    <= sh_val_d;
            sh_dp_q     <= sh_dp_d;
            sh_blz_q    <= sh_blz_d;
            sh_blk_q    <= sh_blk_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            disp_blz_q  <= disp_blz_d;
            disp_blk_q  <= disp_blk_d;
            fd_q        <= fd_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sel_q       <= sel_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_sel    = sel_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;
    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        blink_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .dp(dp),
        .dig_sel(dig_sel), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; sampled on the falling edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #20000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [6:0] g0000 [4] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    logic [6:0] g12af [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    logic [6:0] g0050 [4] = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
    logic       d0050 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0] g0007 [4] = '{7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000};
    logic [6:0] g3456 [4] = '{7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000};
    logic [6:0] g9876 [4] = '{7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [6:0] g0001 [4] = '{7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000};

    function automatic int didx(input int k);
        return ((k - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] sel_of(input int k);
        logic [3:0] s;
        s = 4'b0001 << didx(k);
        return ~s;
    endfunction

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic blz, input logic blk);
        value = v; dp_in = d; blank_lz = blz; blink_en = blk; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF; blank_lz = 1'b0; blink_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b exp 1111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
        checks++; if (dig_sel !== 4'hF) begin errors++; $display("FAIL reset_sel got %b exp 1111", dig_sel); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
        load = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_scan_default;
        for (int k = 1; k <= 32; k++) begin
            wait_to(k);
            checks++; if (dig_sel !== sel_of(k)) begin errors++; $display("FAIL scan_sel k=%0d got %b exp %b", k, dig_sel, sel_of(k)); end
            checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL scan_seg k=%0d got %b exp 1000000", k, seg); end
            checks++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp k=%0d got %b exp 1", k, dp); end
            checks++; if (frame_done !== (k % 16 == 0)) begin errors++; $display("FAIL scan_fd k=%0d got %b exp %b", k, frame_done, (k % 16 == 0)); end
        end
    endtask

    task automatic test_load_midframe;
        logic [6:0] e;
        wait_to(36);
        do_load(16'h12AF, 4'b0000, 1'b0, 1'b0);
        for (int k = 37; k <= 64; k++) begin
            wait_to(k);
            e = (k <= 48) ? g0000[didx(k)] : g12af[didx(k)];
            checks++; if (seg !== e) begin errors++; $display("FAIL midframe_seg k=%0d got %b exp %b", k, seg, e); end
            checks++; if (dig_sel !== sel_of(k)) begin errors++; $display("FAIL midframe_sel k=%0d got %b exp %b", k, dig_sel, sel_of(k)); end
        end
    endtask

    task automatic test_blank_lz;
        logic [6:0] e;
        logic       ed;
        wait_to(70);
        do_load(16'h0050, 4'b0010, 1'b1, 1'b0);
        for (int k = 71; k <= 96; k++) begin
            wait_to(k);
            e  = (k <= 80) ? g12af[didx(k)] : g0050[didx(k)];
            ed = (k <= 80) ? 1'b1 : d0050[didx(k)];
            checks++; if (seg !== e) begin errors++; $display("FAIL blank_seg k=%0d got %b exp %b", k, seg, e); end
            checks++; if (dp !== ed) begin errors++; $display("FAIL blank_dp k=%0d got %b exp %b", k, dp, ed); end
        end
    endtask

    task automatic test_load_on_boundary;
        logic [6:0] e;
        wait_to(100);
        do_load(16'h0007, 4'b0000, 1'b0, 1'b0);
        wait_to(111);
        do_load(16'h3456, 4'b0000, 1'b0, 1'b0);
        for (int k = 113; k <= 144; k++) begin
            wait_to(k);
            e = (k <= 128) ? g0007[didx(k)] : g3456[didx(k)];
            checks++; if (seg !== e) begin errors++; $display("FAIL boundary_seg k=%0d got %b exp %b", k, seg, e); end
            checks++; if (dp !== 1'b1) begin errors++; $display("FAIL boundary_dp k=%0d got %b exp 1", k, dp); end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] e;
        wait_to(150);
        do_load(16'hBCDE, 4'b0000, 1'b0, 1'b0);
        wait_to(155);
        do_load(16'h9876, 4'b0000, 1'b0, 1'b0);
        for (int k = 156; k <= 176; k++) begin
            wait_to(k);
            e = (k <= 160) ? g3456[didx(k)] : g9876[didx(k)];
            checks++; if (seg !== e) begin errors++; $display("FAIL b2b_seg k=%0d got %b exp %b", k, seg, e); end
        end
    endtask

    task automatic test_blink;
        logic [6:0] e;
        logic       ed;
        int         ph;
        wait_to(180);
        do_load(16'h0001, 4'b1111, 1'b0, 1'b1);
        for (int k = 181; k <= 272; k++) begin
            wait_to(k);
            ph = (((k - 1) / 16) / 2) % 2;
            if (k <= 192) begin e = g9876[didx(k)]; ed = 1'b1; end
            else if (ph == 1) begin e = 7'h7F; ed = 1'b1; end
            else begin e = g0001[didx(k)]; ed = 1'b0; end
            checks++; if (seg !== e) begin errors++; $display("FAIL blink_seg k=%0d got %b exp %b", k, seg, e); end
            checks++; if (dp !== ed) begin errors++; $display("FAIL blink_dp k=%0d got %b exp %b", k, dp, ed); end
            checks++; if (dig_sel !== sel_of(k)) begin errors++; $display("FAIL blink_sel k=%0d got %b exp %b", k, dig_sel, sel_of(k)); end
        end
    endtask

    task automatic test_reset_midslot;
        wait_to(274);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL async_seg got %b exp 1111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL async_dp got %b exp 1", dp); end
        checks++; if (dig_sel !== 4'hF) begin errors++; $display("FAIL async_sel got %b exp 1111", dig_sel); end
        repeat (2) @(negedge clk);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL async_fd got %b exp 0", frame_done); end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            wait_to(k);
            checks++; if (dig_sel !== sel_of(k)) begin errors++; $display("FAIL rerun_sel k=%0d got %b exp %b", k, dig_sel, sel_of(k)); end
            checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL rerun_seg k=%0d got %b exp 1000000", k, seg); end
            checks++; if (frame_done !== (k == 16)) begin errors++; $display("FAIL rerun_fd k=%0d got %b exp %b", k, frame_done, (k == 16)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_default();
        test_load_midframe();
        test_blank_lz();
        test_load_on_boundary();
        test_back_to_back();
        test_blink();
        test_reset_midslot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter CLK_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: scan frames per blink half-period, minimum 1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means seg, dp and dig_sel are driven 0 = on.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 value  in  4*NUM_DIGITS  hex digits; nibble 0 is the rightmost digit.
REQ-008 load  in  1  one-cycle strobe that captures value, dp_in, blank_lz and blink_en.
REQ-009 dp_in  in  NUM_DIGITS  per-digit decimal point request.
REQ-010 blank_lz  in  1  enables leading-zero blanking.
REQ-011 blink_en  in  1  enables whole-display blinking.
REQ-012 seg  out  7  segments {g,f,e,d,c,b,a}.
REQ-013 dp  out  1  decimal point of the selected digit.
REQ-014 dig_sel  out  NUM_DIGITS  one-hot digit enable.
REQ-015 frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-016 Slot counter SHALL count 0..CLK_DIV-1 and wrap; the wrap cycle is the slot tick.
REQ-017 On a slot tick, digit index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0; this wrap is the frame boundary.
REQ-018 frame_done SHALL be high for exactly the one cycle in which the index wraps to 0.
REQ-019 load SHALL write the shadow register and set pending; a second load before the frame boundary SHALL overwrite the shadow (last load wins).
REQ-020 At a frame boundary with pending set, shadow SHALL copy to the display register and pending SHALL clear; the display register SHALL never change mid-frame.
REQ-021 If load coincides with a frame boundary, the boundary SHALL copy the old shadow; the new data SHALL stay pending until the next boundary.
REQ-022 Glyphs SHALL use active-high encoding before polarity: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex).
REQ-023 With blank_lz set, a digit SHALL be blank (seg and dp off) when it and every more-significant digit are 0; digit 0 SHALL never be blanked.
REQ-024 Blink phase SHALL toggle after every BLINK_FRAMES frame boundaries; while blink_en is set and the phase is 1, seg and dp SHALL be off and dig_sel SHALL keep scanning.
REQ-025 seg, dp and dig_sel SHALL be registered and SHALL reflect the current index one cycle after it changes.
REQ-026 ACTIVE_LOW SHALL invert seg, dp and dig_sel at the output register only.

Reset
REQ-027 rst_n low SHALL immediately clear the slot counter, index, blink counter and phase, pending, shadow and display register (all 0), and frame_done.
REQ-028 During reset, seg, dp and dig_sel SHALL be all off (all 1 when ACTIVE_LOW=1); a load asserted during reset SHALL be ignored.
REQ-029 After release, the first digit slot SHALL be index 0 with a full CLK_DIV duration, and the display SHALL show "0" on digit 0 with blank_lz=0 semantics.

Verification (NUM_DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1)
REQ-030 Reset release, no load -> dig_sel sequence 1110,1101,1011,0111 (4 cycles each), seg=1000000 on every digit, frame_done every 16 cycles.
REQ-031 load value=16'h12AF mid-frame -> old digits until the frame boundary; next frame digit0..3 seg=0001110,0001000,0100100,1111001.
REQ-032 load 16'h0050, blank_lz=1, dp_in=0010 -> digits 3 and 2 all off, digit 1 seg=0010010 dp=0, digit 0 seg=1000000 dp=1.
REQ-033 load on the exact frame-wrap cycle -> change appears one frame later; two loads in one frame -> only the second is shown.
REQ-034 blink_en=1 -> seg/dp all 1 for 2 frames, then normal for 2 frames, while dig_sel keeps scanning.
REQ-035 rst_n low mid-slot -> outputs go all-off asynchronously; after release, index 0 and display 0.
